// File: rtl/tgfa_acc_pkg.sv
// Shared types and default sizes for the neuron accumulation sequencer.
// Cycles through the neuron inputs of a 10-bit TG adder/ff10 datapath.
package tgfa_acc_pkg;

  localparam int DEF_N_IN  = 10;
  localparam int DEF_WIDTH = 10;
  localparam int DEF_SEL_W = 4;

  localparam logic [DEF_WIDTH-1:0] SAT_MAX = '1;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    ACCUM,
    DRAIN,
    LATCH
  } state_e;

endpackage

// File: rtl/tgfa_seq_cnt.sv
// Up-counter with synchronous clear and enable.
// It holds at LAST instead of wrapping, and tc flags the terminal count.
module tgfa_seq_cnt
  import tgfa_acc_pkg::*;
#(
  parameter int W    = DEF_SEL_W,
  parameter int LAST = DEF_N_IN - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  assign tc  = (cnt_q == W'(LAST));
  assign cnt = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !tc) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tgfa_acc_ctrl.sv
// Handshaked sequencer for the neuron accumulation datapath.
// It clears the registers, steps SEL, drains the pipeline, then latches a saturated result and a fire flag.
module tgfa_acc_ctrl
  import tgfa_acc_pkg::*;
#(
  parameter int N_IN  = DEF_N_IN,
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEL_W = DEF_SEL_W
) (
  input  logic             CK,
  input  logic             RSTB,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIDTH-1:0] THRESH,
  input  logic [WIDTH-1:0] SUM,
  input  logic             CARRY,
  output logic [SEL_W-1:0] SEL,
  output logic             LOAD_EN,
  output logic             SUM_EN,
  output logic             CLR,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT,
  output logic             OVF,
  output logic             FIRE
);

  state_e           state_q, state_d;
  logic             sticky_q, sticky_d;
  logic             done_q, done_d;
  logic             ovf_q, ovf_d;
  logic             fire_q, fire_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [SEL_W-1:0] cnt;
  logic             cnt_tc;
  logic             in_accum;
  logic             in_sum_phase;

  assign in_accum     = (state_q == ACCUM);
  assign in_sum_phase = (state_q == ACCUM) || (state_q == DRAIN);

  // The counter sits at zero outside ACCUM/DRAIN, so each ACCUM phase starts from input 0.
  tgfa_seq_cnt #(
    .W    (SEL_W),
    .LAST (N_IN - 1)
  ) u_cnt (
    .clk   (CK),
    .rst_n (RSTB),
    .clr   (!in_sum_phase),
    .en    (in_accum),
    .cnt   (cnt),
    .tc    (cnt_tc)
  );

  assign SEL     = in_sum_phase ? cnt : '0;
  assign LOAD_EN = in_accum;
  assign SUM_EN  = in_sum_phase;
  assign CLR     = (state_q == CLEAR);
  assign BUSY    = (state_q != IDLE);
  assign DONE    = done_q;
  assign RESULT  = result_q;
  assign OVF     = ovf_q;
  assign FIRE    = fire_q;

  // LATCH sees the final sum, including the carry sampled on the DRAIN edge.
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    fire_d   = fire_q;
    done_d   = 1'b0;
    if (ABORT) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (START) state_d = CLEAR;
        end
        CLEAR: begin
          sticky_d = 1'b0;
          state_d  = ACCUM;
        end
        ACCUM: begin
          sticky_d = sticky_q | CARRY;
          if (cnt_tc) state_d = DRAIN;
        end
        DRAIN: begin
          sticky_d = sticky_q | CARRY;
          state_d  = LATCH;
        end
        LATCH: begin
          result_d = sticky_q ? {WIDTH{1'b1}} : SUM;
          ovf_d    = sticky_q;
          fire_d   = sticky_q | (SUM >= THRESH);
          done_d   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CK or negedge RSTB) begin
    if (!RSTB) begin
      state_q  <= IDLE;
      sticky_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      fire_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      fire_q   <= fire_d;
      result_q <= result_d;
    end
  end

endmodule
